// File: rtl/tron_pkg.sv
// Shared constants, colours, FSM state encoding and address helpers for the Tron plot engine.
package tron_pkg;

    localparam int unsigned SCR_W = 160;
    localparam int unsigned SCR_H = 120;
    localparam int unsigned CELLS = SCR_W * SCR_H;
    localparam int unsigned X_W   = 8;
    localparam int unsigned Y_W   = 7;
    localparam int unsigned A_W   = 15;
    localparam int unsigned C_W   = 3;

    localparam logic [C_W-1:0] COL_CLEAR  = 3'b000;
    localparam logic [C_W-1:0] COL_P1     = 3'b001;
    localparam logic [C_W-1:0] COL_P2     = 3'b100;
    localparam logic [C_W-1:0] COL_BORDER = 3'b111;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_CLEAR = 3'd1;
    localparam state_t ST_WAIT  = 3'd2;
    localparam state_t ST_RD1   = 3'd3;
    localparam state_t ST_CHK1  = 3'd4;
    localparam state_t ST_RD2   = 3'd5;
    localparam state_t ST_CHK2  = 3'd6;
    localparam state_t ST_OVER  = 3'd7;

    // y*160 + x built as y*128 + y*32 + x
    function automatic logic [A_W-1:0] cell_addr(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return (A_W'(y) << 7) + (A_W'(y) << 5) + A_W'(x);
    endfunction

    function automatic logic in_range(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return (x < X_W'(SCR_W)) && (y < Y_W'(SCR_H));
    endfunction

endpackage

// File: rtl/tron_if.sv
// Game control, player heads and VGA adapter signals of the Tron plot engine.
interface tron_if;
    import tron_pkg::*;

    logic           start;
    logic           tick;
    logic [X_W-1:0] p1_x;
    logic [Y_W-1:0] p1_y;
    logic [X_W-1:0] p2_x;
    logic [Y_W-1:0] p2_y;
    logic [X_W-1:0] vga_x;
    logic [Y_W-1:0] vga_y;
    logic [C_W-1:0] vga_colour;
    logic           vga_plot;
    logic           p1_dead;
    logic           p2_dead;
    logic           busy;
    logic           tick_miss;

    modport master (
        output start, tick, p1_x, p1_y, p2_x, p2_y,
        input  vga_x, vga_y, vga_colour, vga_plot, p1_dead, p2_dead, busy, tick_miss
    );

    modport slave (
        input  start, tick, p1_x, p1_y, p2_x, p2_y,
        output vga_x, vga_y, vga_colour, vga_plot, p1_dead, p2_dead, busy, tick_miss
    );

endinterface

// File: rtl/tron_occupancy_ram.sv
// 19200x1 single-port synchronous occupancy RAM, one-cycle read latency.
module tron_occupancy_ram
    import tron_pkg::*;
(
    input  logic           clk,
    input  logic [A_W-1:0] addr,
    input  logic           re,
    input  logic           we,
    input  logic           wdata,
    output logic           rdata
);

    logic mem [CELLS];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/tron_plot_engine.sv
// Tron game step engine: clears the board, checks both heads against occupancy and plots survivors.
// Optional build macro TRON_BORDER_EN paints a lethal border during the clear sweep.
module tron_plot_engine
    import tron_pkg::*;
(
    input logic   clk,
    input logic   resetn,
    tron_if.slave bus
);

    state_t         state, state_nx;
    logic [X_W-1:0] cx, cx_nx, h1x, h1x_nx, h2x, h2x_nx, vga_x, vga_x_nx;
    logic [Y_W-1:0] cy, cy_nx, h1y, h1y_nx, h2y, h2y_nx, vga_y, vga_y_nx;
    logic [C_W-1:0] vga_colour, vga_colour_nx;
    logic           vga_plot, vga_plot_nx;
    logic           busy, busy_nx;
    logic           tick_miss, tick_miss_nx;
    logic           p1_dead, p1_dead_nx;
    logic           p2_dead, p2_dead_nx;

    logic [A_W-1:0] ram_addr;
    logic           ram_re, ram_we, ram_wdata, ram_rdata;
    logic           border_c, heads_eq_c, rng1_c, rng2_c;

    tron_occupancy_ram u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .re    (ram_re),
        .we    (ram_we),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

`ifdef TRON_BORDER_EN
    assign border_c = (cx == '0) || (cx == X_W'(SCR_W - 1)) || (cy == '0) || (cy == Y_W'(SCR_H - 1));
`else
    assign border_c = 1'b0;
`endif

    assign heads_eq_c = (h1x == h2x) && (h1y == h2y);
    assign rng1_c     = in_range(h1x, h1y);
    assign rng2_c     = in_range(h2x, h2y);

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nx;
    end

    // Next state, datapath and registered-output next values
    always_comb begin
        state_nx      = state;
        cx_nx         = cx;
        cy_nx         = cy;
        h1x_nx        = h1x;
        h1y_nx        = h1y;
        h2x_nx        = h2x;
        h2y_nx        = h2y;
        p1_dead_nx    = p1_dead;
        p2_dead_nx    = p2_dead;
        vga_x_nx      = vga_x;
        vga_y_nx      = vga_y;
        vga_colour_nx = vga_colour;
        vga_plot_nx   = 1'b0;
        tick_miss_nx  = 1'b0;
        ram_addr      = cell_addr(h1x, h1y);
        ram_re        = 1'b0;
        ram_we        = 1'b0;
        ram_wdata     = 1'b0;

        case (state)
            ST_CLEAR: begin
                ram_addr      = cell_addr(cx, cy);
                ram_we        = 1'b1;
                ram_wdata     = border_c;
                vga_x_nx      = cx;
                vga_y_nx      = cy;
                vga_colour_nx = border_c ? COL_BORDER : COL_CLEAR;
                vga_plot_nx   = 1'b1;
                tick_miss_nx  = bus.tick;
                if (cx == X_W'(SCR_W - 1)) begin
                    cx_nx = '0;
                    if (cy == Y_W'(SCR_H - 1)) begin
                        cy_nx    = '0;
                        state_nx = ST_WAIT;
                    end else begin
                        cy_nx = cy + Y_W'(1);
                    end
                end else begin
                    cx_nx = cx + X_W'(1);
                end
            end
            ST_WAIT: begin
                if (bus.tick) begin
                    h1x_nx   = bus.p1_x;
                    h1y_nx   = bus.p1_y;
                    h2x_nx   = bus.p2_x;
                    h2y_nx   = bus.p2_y;
                    state_nx = ST_RD1;
                end
            end
            ST_RD1: begin
                ram_re       = !p1_dead && rng1_c;
                tick_miss_nx = bus.tick;
                state_nx     = ST_CHK1;
            end
            ST_CHK1: begin
                tick_miss_nx = bus.tick;
                // Out-of-range heads never read the RAM, so rdata is only trusted in range
                if (!p1_dead) begin
                    if (!rng1_c || heads_eq_c || ram_rdata) begin
                        p1_dead_nx = 1'b1;
                    end else begin
                        ram_we        = 1'b1;
                        ram_wdata     = 1'b1;
                        vga_x_nx      = h1x;
                        vga_y_nx      = h1y;
                        vga_colour_nx = COL_P1;
                        vga_plot_nx   = 1'b1;
                    end
                end
                if (heads_eq_c) p2_dead_nx = 1'b1;
                state_nx = ST_RD2;
            end
            ST_RD2: begin
                ram_addr     = cell_addr(h2x, h2y);
                ram_re       = !p2_dead && rng2_c;
                tick_miss_nx = bus.tick;
                state_nx     = ST_CHK2;
            end
            ST_CHK2: begin
                ram_addr     = cell_addr(h2x, h2y);
                tick_miss_nx = bus.tick;
                if (!p2_dead) begin
                    if (!rng2_c || ram_rdata) begin
                        p2_dead_nx = 1'b1;
                    end else begin
                        ram_we        = 1'b1;
                        ram_wdata     = 1'b1;
                        vga_x_nx      = h2x;
                        vga_y_nx      = h2y;
                        vga_colour_nx = COL_P2;
                        vga_plot_nx   = 1'b1;
                    end
                end
                state_nx = (p1_dead_nx || p2_dead_nx) ? ST_OVER : ST_WAIT;
            end
            default: ;
        endcase

        // Start overrides everything, including a coincident tick
        if (bus.start) begin
            state_nx     = ST_CLEAR;
            cx_nx        = '0;
            cy_nx        = '0;
            p1_dead_nx   = 1'b0;
            p2_dead_nx   = 1'b0;
            vga_plot_nx  = 1'b0;
            tick_miss_nx = 1'b0;
            ram_we       = 1'b0;
            ram_re       = 1'b0;
        end

        busy_nx = (state_nx != ST_IDLE) && (state_nx != ST_WAIT) && (state_nx != ST_OVER);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cx         <= '0;
            cy         <= '0;
            h1x        <= '0;
            h1y        <= '0;
            h2x        <= '0;
            h2y        <= '0;
            p1_dead    <= 1'b0;
            p2_dead    <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            busy       <= 1'b0;
            tick_miss  <= 1'b0;
        end else begin
            cx         <= cx_nx;
            cy         <= cy_nx;
            h1x        <= h1x_nx;
            h1y        <= h1y_nx;
            h2x        <= h2x_nx;
            h2y        <= h2y_nx;
            p1_dead    <= p1_dead_nx;
            p2_dead    <= p2_dead_nx;
            vga_x      <= vga_x_nx;
            vga_y      <= vga_y_nx;
            vga_colour <= vga_colour_nx;
            vga_plot   <= vga_plot_nx;
            busy       <= busy_nx;
            tick_miss  <= tick_miss_nx;
        end
    end

    assign bus.vga_x      = vga_x;
    assign bus.vga_y      = vga_y;
    assign bus.vga_colour = vga_colour;
    assign bus.vga_plot   = vga_plot;
    assign bus.p1_dead    = p1_dead;
    assign bus.p2_dead    = p2_dead;
    assign bus.busy       = busy;
    assign bus.tick_miss  = tick_miss;

endmodule

// File: doc/tron_plot_engine.md
TRON_PLOT_ENGINE -- requirements
Module: tron_plot_engine

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock for all logic (50 MHz).
REQ-002 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port start, input, 1 bit: one-cycle pulse that begins a new game (board clear).
REQ-004 SHALL have port tick, input, 1 bit: one-cycle pulse, one game step.
REQ-005 SHALL have ports p1_x and p2_x, input, 8 bits: player head column.
REQ-006 SHALL have ports p1_y and p2_y, input, 7 bits: player head row.
REQ-007 SHALL have ports vga_x (8 bits), vga_y (7 bits), vga_colour (3 bits) and vga_plot (1 bit), all outputs, registered, driving the 160x120 VGA adapter directly.
REQ-008 SHALL have ports p1_dead and p2_dead, output, 1 bit each: sticky death flags.
REQ-009 SHALL have port busy, output, 1 bit: high while clearing or processing a step.
REQ-010 SHALL have port tick_miss, output, 1 bit: one-cycle pulse when a tick is dropped.

Function
REQ-011 SHALL implement states IDLE, CLEAR, WAIT, RD1, CHK1, RD2, CHK2, OVER.
REQ-012 SHALL enter CLEAR on start from any state, sweep all 19200 cells x 0..159 inner and y 0..119 outer, writing occupancy 0 and plotting colour 3'b000 at one cell per cycle, then go to WAIT.
REQ-013 SHALL clear p1_dead and p2_dead on entry to CLEAR.
REQ-014 SHALL, in WAIT on tick, latch all four head coordinates and go to RD1; when tick is sampled in WAIT at cycle T, the P1 plot SHALL appear at T+3 and the P2 plot at T+5.
REQ-015 SHALL compute the occupancy address as y*160+x (15 bits), using shifts and adds only.
REQ-016 SHALL mark a player dead without a memory read when x>159 or y>119.
REQ-017 SHALL mark a player dead when the occupancy read returns 1.
REQ-018 SHALL mark both players dead when the latched P1 and P2 heads are equal, even if the cell is free.
REQ-019 SHALL, for a surviving player, write occupancy 1 and assert vga_plot for exactly one cycle with that head's coordinates and colour (P1 3'b001, P2 3'b100).
REQ-020 SHALL skip the read, check and plot for a player whose flag is already set.
REQ-021 SHALL go to OVER after CHK2 if either flag is set, otherwise back to WAIT; OVER SHALL leave only on start.
REQ-022 SHALL ignore tick outside WAIT and pulse tick_miss when tick arrives in RD1..CHK2 or CLEAR.
REQ-023 SHALL, when tick and start coincide, let start win, with no tick_miss.
REQ-024 SHALL hold vga_plot low in IDLE, WAIT and OVER.

Reset
REQ-025 SHALL, on resetn low, immediately force state IDLE; vga_plot, busy, tick_miss, p1_dead and p2_dead to 0; and vga_x, vga_y and vga_colour to 0.
REQ-026 SHALL NOT clear the occupancy memory on reset; a start is required before play.
REQ-027 SHALL, on reset asserted mid-CLEAR, abandon the sweep; the next start restarts it from cell 0.

Configuration
REQ-028 SHALL, with TRON_BORDER_EN defined, plot border cells (x=0, x=159, y=0, y=119) in 3'b111 during CLEAR and write their occupancy as 1, so a player touching the border dies.
REQ-029 SHALL, without TRON_BORDER_EN, clear border cells like any other cell, with only the REQ-016 range check applying.

Structure
REQ-030 SHALL place in package tron_pkg: screen width and height constants (160, 120), the colour constants, and the state enumeration.
REQ-031 SHALL use one sub-module, tron_occupancy_ram: 19200x1 single-port synchronous RAM with one-cycle read latency and write-enable.
REQ-032 SHALL register all outputs; no combinational path from any input to any output.

Verification
REQ-033 Reset then start -> busy high for 19200 cycles, 19200 plots in raster order, then WAIT.
REQ-034 Heads P1 (25,25), P2 (75,75), tick at T -> plot (25,25) colour 001 at T+3, plot (75,75) colour 100 at T+5, no deaths.
REQ-035 Repeat the same P1 head on the next tick -> p1_dead=1, no P1 plot, P2 plotted, state OVER.
REQ-036 Both heads (40,40) -> both dead, no plots; with P1 at x=160 -> p1_dead only, no RAM read.
REQ-037 Tick two cycles after a previous tick -> tick_miss pulse and no extra plots; tick together with start -> clear begins, no tick_miss.
REQ-038 TRON_BORDER_EN defined, head (0,50) after clear -> death; same test without the macro -> survives and is plotted.
